// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared state encoding, frame constants and checksum helper for the frequency-measurement sequencer
package freq_meas_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_LATCH = 3'd3,
    S_SEND  = 3'd4,
    S_GAP   = 3'd5
  } state_t;
  localparam logic [7:0] FRAME_HDR = 8'hFF;
  localparam logic [7:0] TAG_OK    = 8'h00;
  localparam logic [7:0] TAG_OVF   = 8'hEE;
  localparam logic [7:0] TAG_TMO   = 8'hEF;
  localparam int         FRAME_LEN = 7;
  function automatic logic [7:0] frame_chk(input logic [7:0] tag, input logic [31:0] r);
    return tag ^ r[7:0] ^ r[15:8] ^ r[23:16] ^ r[31:24];
  endfunction
endpackage

// File: rtl/freq_frame_tx.sv
// freq_frame_tx: latches a tagged result and streams its 7-byte frame over the sendEnable/sendBusy handshake
module freq_frame_tx
  import freq_meas_pkg::*;
(
  input  logic        baseClk,
  input  logic        hard_Clr,
  input  logic        load,
  input  logic [7:0]  tag_in,
  input  logic [31:0] result_in,
  input  logic        sendBusy,
  output logic [7:0]  data,
  output logic        sendEnable,
  output logic        done
);
  logic [7:0]  tag;
  logic [31:0] result;
  logic [2:0]  idx;
  logic        active;
  logic        accept;
  logic [7:0]  cur;
  assign accept = sendEnable && !sendBusy;
  assign done = accept && idx == 3'(FRAME_LEN - 1);
  always_comb
    cur = idx == 3'd0 ? FRAME_HDR :
          idx == 3'd1 ? tag :
          idx == 3'd2 ? result[7:0] :
          idx == 3'd3 ? result[15:8] :
          idx == 3'd4 ? result[23:16] :
          idx == 3'd5 ? result[31:24] : frame_chk(tag, result);
  always_ff @(posedge baseClk)
    if (hard_Clr) begin
      tag <= '0;
      result <= '0;
      idx <= '0;
      active <= 1'b0;
      sendEnable <= 1'b0;
      data <= '0;
    end else if (load) begin
      tag <= tag_in;
      result <= result_in;
      idx <= '0;
      active <= 1'b1;
      sendEnable <= 1'b0;
    end else if (accept) begin
      sendEnable <= 1'b0;
      idx <= idx + 3'd1;
      active <= !done;
    end else if (active && !sendEnable) begin
      sendEnable <= 1'b1;
      data <= cur;
    end
endmodule

// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: sequences clear/run/latch of the reciprocal counter and sends each result as a 7-byte frame
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
  parameter logic [15:0] GAP_CYC     = 16'd1000,
  parameter int          CNT_W       = 32
) (
  input  logic             baseClk,
  input  logic             hard_Clr,
  input  logic             start,
  input  logic             cfg_auto,
  output logic             cnt_clr,
  output logic             cnt_run,
  input  logic             cnt_done,
  input  logic             cnt_ovf,
  input  logic [CNT_W-1:0] cnt_base,
  output logic [7:0]       data,
  output logic             sendEnable,
  input  logic             sendBusy,
  output logic             busy,
  output logic [7:0]       err_cnt
);
  state_t      state;
  logic [31:0] timer;
  logic [15:0] gap;
  logic        clr_n;
  logic [7:0]  tag;
  logic        tx_done;
  assign busy = state != S_IDLE;
  freq_frame_tx u_tx (
    .baseClk   (baseClk),
    .hard_Clr  (hard_Clr),
    .load      (state == S_LATCH),
    .tag_in    (tag),
    .result_in (tag == TAG_OK ? 32'(cnt_base) : 32'd0),
    .sendBusy  (sendBusy),
    .data      (data),
    .sendEnable(sendEnable),
    .done      (tx_done)
  );
  always_ff @(posedge baseClk)
    if (hard_Clr) begin
      state <= S_IDLE;
      cnt_clr <= 1'b0;
      cnt_run <= 1'b0;
      err_cnt <= '0;
      timer <= '0;
      gap <= '0;
      clr_n <= 1'b0;
      tag <= TAG_OK;
    end else
      case (state)
        S_IDLE:
          if (start || cfg_auto) begin
            state <= S_CLEAR;
            cnt_clr <= 1'b1;
            clr_n <= 1'b0;
          end
        S_CLEAR: begin
          clr_n <= 1'b1;
          if (clr_n) begin
            state <= S_RUN;
            cnt_clr <= 1'b0;
            cnt_run <= 1'b1;
            timer <= '0;
          end
        end
        S_RUN: begin
          timer <= timer + 32'd1;
          if (cnt_ovf || cnt_done || timer == TIMEOUT_CYC - 32'd1) begin
            state <= S_LATCH;
            cnt_run <= 1'b0;
            tag <= cnt_ovf ? TAG_OVF : cnt_done ? TAG_OK : TAG_TMO;
          end
        end
        S_LATCH: begin
          state <= S_SEND;
          if (tag != TAG_OK && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
        end
        S_SEND:
          if (tx_done) begin
            state <= cfg_auto ? S_GAP : S_IDLE;
            gap <= '0;
          end
        S_GAP: begin
          gap <= gap + 16'd1;
          if (gap == GAP_CYC - 16'd1) begin
            state <= cfg_auto ? S_CLEAR : S_IDLE;
            cnt_clr <= cfg_auto;
            clr_n <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// tb_freq_meas_sequencer: directed self-checking bench for freq_meas_sequencer
module tb_freq_meas_sequencer;
  typedef logic [7:0] frame_t [7];
  logic        baseClk = 1'b0;
  logic        hard_Clr = 1'b1;
  logic        start = 1'b0;
  logic        cfg_auto = 1'b0;
  logic        cnt_done = 1'b0;
  logic        cnt_ovf = 1'b0;
  logic        sendBusy = 1'b0;
  logic [31:0] cnt_base = '0;
  logic        cnt_clr;
  logic        cnt_run;
  logic        sendEnable;
  logic        busy;
  logic [7:0]  data;
  logic [7:0]  err_cnt;
  int          checks = 0;
  int          errors = 0;
  frame_t f_ok   = '{8'hFF, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
  frame_t f_ovf  = '{8'hFF, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEE};
  frame_t f_tmo  = '{8'hFF, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF};
  frame_t f_auto = '{8'hFF, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
  always #5 baseClk = ~baseClk;
  freq_meas_sequencer #(
    .TIMEOUT_CYC(32'd100),
    .GAP_CYC    (16'd10),
    .CNT_W      (32)
  ) dut (
    .baseClk   (baseClk),
    .hard_Clr  (hard_Clr),
    .start     (start),
    .cfg_auto  (cfg_auto),
    .cnt_clr   (cnt_clr),
    .cnt_run   (cnt_run),
    .cnt_done  (cnt_done),
    .cnt_ovf   (cnt_ovf),
    .cnt_base  (cnt_base),
    .data      (data),
    .sendEnable(sendEnable),
    .sendBusy  (sendBusy),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge baseClk);
  endtask
  task automatic wait_run(input string tag);
    int n = 0;
    while (!cnt_run && n < 50) begin
      tick();
      n++;
    end
    check({tag, " run"}, 32'(cnt_run), 'h1);
  endtask
  task automatic recv_frame(input string tag, input frame_t exp, input int bp, input int nb);
    int bad = 0;
    for (int k = 0; k < nb; k++) begin
      int n = 0;
      while (!sendEnable && n < 400) begin
        tick();
        n++;
      end
      if (!sendEnable) begin
        check($sformatf("%s present%0d", tag, k), 32'(sendEnable), 'h1);
        return;
      end
      check($sformatf("%s byte%0d", tag, k), 32'(data), 32'(exp[k]));
      tick();
      check($sformatf("%s gap%0d", tag, k), 32'(sendEnable), 'h0);
      if (bp > 0 && k < 6) begin
        sendBusy = 1'b1;
        repeat (bp) begin
          tick();
          if (!sendEnable || data !== exp[k+1]) bad++;
        end
        sendBusy = 1'b0;
      end
    end
    if (bp > 0) check({tag, " stable"}, bad, 'h0);
  endtask
  task automatic shot(input string tag, input logic [31:0] base, input frame_t exp, input int bp);
    int n = 0;
    cnt_base = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 'h1);
    while (cnt_clr && n < 10) begin
      n++;
      tick();
    end
    check({tag, " clr len"}, n, 'd2);
    check({tag, " run"}, 32'(cnt_run), 'h1);
    tick(39);
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    check({tag, " latch"}, 32'(cnt_run), 'h0);
    recv_frame(tag, exp, bp, 7);
    check({tag, " idle"}, 32'(busy), 'h0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    tick(3);
    check("rst busy", 32'(busy), 'h0);
    check("rst cnt_clr", 32'(cnt_clr), 'h0);
    check("rst cnt_run", 32'(cnt_run), 'h0);
    check("rst sendEnable", 32'(sendEnable), 'h0);
    check("rst data", 32'(data), 'h0);
    check("rst err_cnt", 32'(err_cnt), 'h0);
    hard_Clr = 1'b0;
    cnt_done = 1'b1;
    cnt_ovf = 1'b1;
    tick(3);
    cnt_done = 1'b0;
    cnt_ovf = 1'b0;
    check("idle ignores done", 32'(busy), 'h0);
    check("idle err_cnt", 32'(err_cnt), 'h0);
    shot("single", 'h12345678, f_ok, 0);
    shot("bp", 'h12345678, f_ok, 5);
    check("bp err_cnt", 32'(err_cnt), 'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("ovf");
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt_ovf = 1'b1;
    cnt_done = 1'b1;
    tick();
    cnt_ovf = 1'b0;
    cnt_done = 1'b0;
    recv_frame("ovf", f_ovf, 0, 7);
    check("ovf err_cnt", 32'(err_cnt), 'h1);
    tick(5);
    check("start not queued", 32'(busy), 'h0);
    check("start not queued clr", 32'(cnt_clr), 'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("tmo");
    n = 0;
    while (cnt_run && n < 200) begin
      n++;
      tick();
    end
    check("tmo run cycles", n, 'd100);
    recv_frame("tmo", f_tmo, 0, 7);
    check("tmo err_cnt", 32'(err_cnt), 'h2);
    for (int i = 0; i < 300; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 400) begin
        tick();
        n++;
      end
      if (busy) begin
        check("sat wait", 32'(busy), 'h0);
        break;
      end
      if (i == 251) check("sat err_cnt 254", 32'(err_cnt), 'hFE);
    end
    check("sat err_cnt", 32'(err_cnt), 'hFF);
    cnt_base = 'hA1B2C3D4;
    cfg_auto = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_run($sformatf("auto%0d", f));
      if (f == 2) cfg_auto = 1'b0;
      cnt_done = 1'b1;
      tick();
      cnt_done = 1'b0;
      recv_frame($sformatf("auto%0d", f), f_auto, 0, 7);
      if (f < 2) begin
        n = 0;
        while (!cnt_clr && n < 100) begin
          n++;
          tick();
        end
        check($sformatf("auto%0d gap len", f), n, 'd10);
      end
    end
    check("auto stop busy", 32'(busy), 'h0);
    tick(15);
    check("auto stop idle", 32'(busy), 'h0);
    check("auto stop clr", 32'(cnt_clr), 'h0);
    cnt_base = 'h12345678;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run("rst");
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    recv_frame("rst", f_ok, 0, 3);
    n = 0;
    while (!sendEnable && n < 20) begin
      tick();
      n++;
    end
    check("rst byte3", 32'(data), 'h56);
    hard_Clr = 1'b1;
    tick();
    check("abort sendEnable", 32'(sendEnable), 'h0);
    check("abort data", 32'(data), 'h0);
    check("abort busy", 32'(busy), 'h0);
    check("abort err_cnt", 32'(err_cnt), 'h0);
    check("abort cnt_run", 32'(cnt_run), 'h0);
    hard_Clr = 1'b0;
    n = 0;
    repeat (20) begin
      tick();
      if (sendEnable) n++;
    end
    check("abort no bytes", n, 'd0);
    shot("after rst", 'h12345678, f_ok, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_meas_sequencer.md
Name: freq_meas_sequencer

Overview:
- Top-level controller that sequences the reciprocal frequency-counter datapath: clear, gate/run, completion or timeout detection, and result latching.
- Formats each result into a fixed 7-byte frame and streams it byte-by-byte to the SPI/byte transmitter through the sendEnable/sendBusy handshake.
- Supports single-shot (start pulse) and free-running (auto) modes, with a programmable gap between measurements.

Parameters:
- TIMEOUT_CYC, 32'd50_000_000, max baseClk cycles in RUN before abort with error frame.
- GAP_CYC, 16'd1000, baseClk cycles idle between frames in auto mode.
- CNT_W, 32, width of datapath base count.

Ports:
- baseClk  in  1  system/reference clock; all logic on posedge.
- hard_Clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle request for a measurement; ignored unless state is IDLE.
- cfg_auto  in  1  1 = restart automatically after GAP; sampled in IDLE and at end of GAP.
- cnt_clr  out  1  clear to counter datapath.
- cnt_run  out  1  enable to counter datapath.
- cnt_done  in  1  datapath finished its gate (sync to baseClk).
- cnt_ovf  in  1  datapath counter overflow.
- cnt_base  in  CNT_W  datapath base-clock count.
- data  out  8  byte to transmitter.
- sendEnable  out  1  byte valid.
- sendBusy  in  1  transmitter busy; byte accepted on cycle sendEnable && !sendBusy.
- busy  out  1  high in every state except IDLE.
- err_cnt  out  8  saturating count of error frames.

Behaviour:
- Reset (hard_Clr=1 at posedge): state=IDLE; cnt_clr=0, cnt_run=0, data=8'h00, sendEnable=0, busy=0, err_cnt=0; latched result, timer, byte index cleared. Reset mid-frame aborts the frame immediately; no partial bytes after reset.
- States: IDLE, CLEAR, RUN, LATCH, SEND, GAP.
- IDLE: go to CLEAR when start=1, or when cfg_auto=1.
- CLEAR: cnt_clr=1 for exactly 2 cycles, then RUN; timer reset to 0.
- RUN: cnt_run=1; timer increments each cycle.
  - cnt_ovf=1 -> LATCH with tag=8'hEE.
  - Else cnt_done=1 -> LATCH with tag=8'h00.
  - Else timer==TIMEOUT_CYC-1 -> LATCH with tag=8'hEF.
  - Priority when simultaneous: ovf > done > timeout.
- LATCH (1 cycle): cnt_run=0; result <= cnt_base (forced 0 for tags EE/EF); byte index=0; err_cnt += 1 for tags EE/EF, saturating at 8'hFF.
- SEND: frame order is 8'hFF, tag, result[7:0], [15:8], [23:16], [31:24], chk.
  - chk = XOR of bytes 1..5 (tag and four result bytes).
  - sendEnable held high with data stable until accepted.
  - After acceptance, sendEnable=0 for at least 1 cycle, then the next byte is presented. No byte is ever presented twice or skipped.
  - After byte 6 is accepted: go to GAP if cfg_auto=1, else IDLE.
- GAP: counts GAP_CYC cycles with cnt_clr=0 and cnt_run=0, then CLEAR if cfg_auto=1, else IDLE.
- start while busy is ignored and not queued.
- cnt_done/cnt_ovf outside RUN are ignored.
- Timer width is 32 bits; it cannot wrap because timeout fires first.

Decomposition:
- Shared package freq_meas_pkg holds: state encoding (3-bit localparams), FRAME_HDR=8'hFF, TAG_OK=8'h00, TAG_OVF=8'hEE, TAG_TMO=8'hEF, FRAME_LEN=7.
- One sub-module, freq_frame_tx: holds the latched result and tag, byte index, checksum, and the sendEnable/sendBusy handshake. It exposes load/done to the sequencer FSM.

Test Plan:
- Single shot: start pulse, cnt_done after 40 cycles, cnt_base=32'h12345678 -> cnt_clr 2 cycles, then frame FF 00 78 56 34 12 chk=0x08, then IDLE with busy=0.
- Backpressure: sendBusy high 5 cycles after each acceptance -> each byte accepted exactly once, data stable while sendEnable=1, same 7 bytes.
- Overflow with done in the same cycle -> tag EE, result bytes 00, chk=0xEE, err_cnt=1.
- Timeout: TIMEOUT_CYC=100, cnt_done never asserted -> LATCH after exactly 100 RUN cycles, tag EF, err_cnt increments; 300 forced timeouts saturate err_cnt at 8'hFF.
- Auto mode: cfg_auto=1, GAP_CYC=10 -> 3 back-to-back frames, exactly 10 idle cycles between last acceptance and next cnt_clr; deassert cfg_auto -> returns to IDLE after the current frame.
- hard_Clr asserted during byte 3 of SEND -> next cycle: IDLE, sendEnable=0, data=00; a subsequent start produces a full, correct frame.
